// File: rtl/palette_pkg.sv
// palette_pkg: shared types and constants for palette_compositor.
//   rgb_t            - 8/8/8 colour triple {r,g,b}
//   MAX_LAYERS       - hard upper bound on NUM_LAYERS (pal_wr_layer is 3 bits)
//   DEFAULT_BG_PAL   - power-on palette for layer 0 (stage background)
//   DEFAULT_SPR_PAL  - power-on palette for sprite layers 1..N-1
//   fade_state_e     - state encoding of the optional fade sequencer
//   default_entry()  - reset value lookup; entries past 7 are black
package palette_pkg;

    localparam int MAX_LAYERS = 8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t DEFAULT_BG_PAL [8] = '{
        rgb_t'(24'h000000), rgb_t'(24'hFFFFFF), rgb_t'(24'h0000FF), rgb_t'(24'hB6B6AA),
        rgb_t'(24'h000000), rgb_t'(24'h000000), rgb_t'(24'h000000), rgb_t'(24'h000000)
    };

    localparam rgb_t DEFAULT_SPR_PAL [8] = '{
        rgb_t'(24'h000000), rgb_t'(24'hFF0000), rgb_t'(24'hFFFFFF), rgb_t'(24'h6D6D6D),
        rgb_t'(24'hFFFF00), rgb_t'(24'h00FF00), rgb_t'(24'hFFB600), rgb_t'(24'h6DB600)
    };

    typedef enum logic {
        IDLE,
        FADING
    } fade_state_e;

    function automatic rgb_t default_entry(input bit is_bg, input int idx);
        rgb_t e;
        e = '0;
        if (idx >= 0 && idx < 8) begin
            e = is_bg ? DEFAULT_BG_PAL[idx[2:0]] : DEFAULT_SPR_PAL[idx[2:0]];
        end
        return e;
    endfunction

endpackage

// File: rtl/palette_bank.sv
// palette_bank: one layer's palette register file.
//   Clk, Reset          - pixel clock, async active-high reset (loads defaults)
//   wr_en_i             - write strobe (already qualified by handshake + layer decode)
//   wr_idx_i, wr_rgb_i  - entry and {R,G,B} data to write
//   rd_idx_i, rd_rgb_o  - combinational read; a same-cycle write is not yet visible
// IS_BG selects the background or sprite default table on reset.
module palette_bank
    import palette_pkg::*;
#(
    parameter int IDX_W   = 3,
    parameter int COLOR_W = 8,
    parameter bit IS_BG   = 1'b0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [3*COLOR_W-1:0] wr_rgb_i,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic [3*COLOR_W-1:0] rd_rgb_o
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int RGB_W = 3 * COLOR_W;

    // Defaults are authored as 8-bit channels; MSB-align them to COLOR_W.
    function automatic logic [RGB_W-1:0] reset_entry(input int i);
        rgb_t             e;
        logic [7:0]       ch;
        logic [RGB_W-1:0] f;
        logic [RGB_W-1:0] v;
        e = default_entry(IS_BG, i);
        v = '0;
        for (int c = 0; c < 3; c++) begin
            ch = (c == 0) ? e.b : (c == 1) ? e.g : e.r;
            if (COLOR_W >= 8) f = RGB_W'(ch) << (COLOR_W - 8);
            else              f = RGB_W'(ch >> (8 - COLOR_W));
            v = v | (f << (c * COLOR_W));
        end
        return v;
    endfunction

    logic [DEPTH-1:0][RGB_W-1:0] mem;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        localparam logic [RGB_W-1:0] RST_VAL = reset_entry(i);
        logic [RGB_W-1:0] ent_q;

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                ent_q <= RST_VAL;
            end else if (wr_en_i && wr_idx_i == IDX_W'(i)) begin
                ent_q <= wr_rgb_i;
            end
        end

        assign mem[i] = ent_q;
    end

    assign rd_rgb_o = mem[rd_idx_i];

endmodule

// File: rtl/palette_compositor.sv
// palette_compositor: 2-stage indexed-colour layer compositor.
//   Clk, Reset                 - pixel clock, async active-high reset
//   DrawX/DrawY/pix_valid/blank_n - pixel stream in
//   layer_en, layer_idx        - per-layer hit flags and packed colour indices
//   pal_wr_*                   - palette write port (valid/ready)
//   out_valid/OutX/OutY        - pixel stream out, 2 cycles later
//   Red/Green/Blue             - composited colour
// Optional: define PALETTE_FADE_EN for frame_tick/fade_go/fade_out/fade_busy
// and a 0..16 brightness level applied in stage 2.
module palette_compositor
    import palette_pkg::*;
#(
    parameter int NUM_LAYERS       = 3,
    parameter int IDX_W            = 3,
    parameter int COLOR_W          = 8,
    parameter int WR_IN_BLANK_ONLY = 1
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [9:0]                  DrawX,
    input  logic [9:0]                  DrawY,
    input  logic                        pix_valid,
    input  logic                        blank_n,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
    input  logic                        pal_wr_valid,
    output logic                        pal_wr_ready,
    input  logic [2:0]                  pal_wr_layer,
    input  logic [IDX_W-1:0]            pal_wr_idx,
    input  logic [3*COLOR_W-1:0]        pal_wr_rgb,
`ifdef PALETTE_FADE_EN
    input  logic                        frame_tick,
    input  logic                        fade_go,
    input  logic                        fade_out,
    output logic                        fade_busy,
`endif
    output logic                        out_valid,
    output logic [9:0]                  OutX,
    output logic [9:0]                  OutY,
    output logic [COLOR_W-1:0]          Red,
    output logic [COLOR_W-1:0]          Green,
    output logic [COLOR_W-1:0]          Blue
);

    localparam int RGB_W = 3 * COLOR_W;

    logic                                 wr_fire;
    logic [NUM_LAYERS-1:0][RGB_W-1:0]     rd_rgb;
    logic [NUM_LAYERS-1:0]                opaque_d;
    logic [NUM_LAYERS-1:0][RGB_W-1:0]     s1_rgb_q;
    logic [NUM_LAYERS-1:0]                s1_opaque_q;
    logic                                 s1_blank_q, s1_valid_q;
    logic [9:0]                           s1_x_q, s1_y_q;
    logic [NUM_LAYERS-1:0][RGB_W-1:0]     chain;
    logic [RGB_W-1:0]                     pix_d;
    logic [RGB_W-1:0]                     out_d;

    assign pal_wr_ready = (WR_IN_BLANK_ONLY == 0) || !blank_n;
    assign wr_fire      = pal_wr_valid && pal_wr_ready;

    // Layer numbers >= NUM_LAYERS match no bank, so those writes are dropped
    // while the handshake still completes.
    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        logic [IDX_W-1:0] idx;
        assign idx = layer_idx[k*IDX_W +: IDX_W];

        palette_bank #(
            .IDX_W   (IDX_W),
            .COLOR_W (COLOR_W),
            .IS_BG   (k == 0)
        ) u_bank (
            .Clk      (Clk),
            .Reset    (Reset),
            .wr_en_i  (wr_fire && pal_wr_layer == 3'(k)),
            .wr_idx_i (pal_wr_idx),
            .wr_rgb_i (pal_wr_rgb),
            .rd_idx_i (idx),
            .rd_rgb_o (rd_rgb[k])
        );

        // Background always shows; sprite index 0 is transparent.
        assign opaque_d[k] = (k == 0) || (layer_en[k] && idx != '0);

        // Priority chain: later (higher) opaque layers override earlier ones.
        if (k == 0) begin : g_base
            assign chain[k] = s1_opaque_q[k] ? s1_rgb_q[k] : '0;
        end else begin : g_pri
            assign chain[k] = s1_opaque_q[k] ? s1_rgb_q[k] : chain[k-1];
        end
    end

    // Stage 1: palette lookups and sideband.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_rgb_q    <= '0;
            s1_opaque_q <= '0;
            s1_blank_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
        end else begin
            s1_rgb_q    <= rd_rgb;
            s1_opaque_q <= opaque_d;
            s1_blank_q  <= blank_n;
            s1_valid_q  <= pix_valid;
            s1_x_q      <= DrawX;
            s1_y_q      <= DrawY;
        end
    end

    assign pix_d = s1_blank_q ? chain[NUM_LAYERS-1] : '0;

`ifdef PALETTE_FADE_EN
    fade_state_e state_q, state_d;
    logic [4:0]  level_q, level_d;
    logic        dir_q, dir_d;     // 1 = fading toward black

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            level_q <= 5'd16;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (fade_go) begin
                    state_d = FADING;
                    dir_d   = fade_out;
                end
            end
            FADING: begin
                if (frame_tick) begin
                    if (dir_q) begin
                        if (level_q != 5'd0) level_d = level_q - 5'd1;
                        if (level_q <= 5'd1) state_d = IDLE;
                    end else begin
                        if (level_q != 5'd16) level_d = level_q + 5'd1;
                        if (level_q >= 5'd15) state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fade_busy = (state_q == FADING);

    // Full level passes the colour through untouched (saturates to max).
    for (genvar c = 0; c < 3; c++) begin : g_fade
        logic [COLOR_W-1:0] chan;
        logic [COLOR_W+4:0] prod;
        assign chan = pix_d[c*COLOR_W +: COLOR_W];
        assign prod = (COLOR_W+5)'(chan) * (COLOR_W+5)'(level_q);
        assign out_d[c*COLOR_W +: COLOR_W] = (level_q == 5'd16) ? chan : prod[COLOR_W+3:4];
    end
`else
    assign out_d = pix_d;
`endif

    // Stage 2: output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            OutX      <= '0;
            OutY      <= '0;
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
        end else begin
            out_valid <= s1_valid_q;
            OutX      <= s1_x_q;
            OutY      <= s1_y_q;
            Red       <= out_d[2*COLOR_W +: COLOR_W];
            Green     <= out_d[COLOR_W +: COLOR_W];
            Blue      <= out_d[0 +: COLOR_W];
        end
    end

endmodule

// File: tb/tb_palette_compositor.sv
module tb_palette_compositor;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY;
    logic       pix_valid, blank_n;
    logic [2:0] layer_en;
    logic [8:0] layer_idx;
    logic       pal_wr_valid, pal_wr_ready;
    logic [2:0] pal_wr_layer, pal_wr_idx;
    logic [23:0] pal_wr_rgb;
    logic       out_valid;
    logic [9:0] OutX, OutY;
    logic [7:0] Red, Green, Blue;
`ifdef PALETTE_FADE_EN
    logic       frame_tick, fade_go, fade_out, fade_busy;
`endif

    palette_compositor #(
        .NUM_LAYERS(3), .IDX_W(3), .COLOR_W(8), .WR_IN_BLANK_ONLY(1)
    ) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .pix_valid(pix_valid), .blank_n(blank_n),
        .layer_en(layer_en), .layer_idx(layer_idx),
        .pal_wr_valid(pal_wr_valid), .pal_wr_ready(pal_wr_ready),
        .pal_wr_layer(pal_wr_layer), .pal_wr_idx(pal_wr_idx), .pal_wr_rgb(pal_wr_rgb),
`ifdef PALETTE_FADE_EN
        .frame_tick(frame_tick), .fade_go(fade_go), .fade_out(fade_out), .fade_busy(fade_busy),
`endif
        .out_valid(out_valid), .OutX(OutX), .OutY(OutY),
        .Red(Red), .Green(Green), .Blue(Blue)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        bl;
        logic        pv;
        logic [2:0]  en;
        logic [8:0]  idx;   // {l2, l1, l0}
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    // Single pixel held for two edges, then checked.
    task automatic look(input string name, input logic [2:0] en, input logic [8:0] idx,
                        input logic [23:0] exp);
        @(negedge Clk);
        blank_n = 1'b1; pix_valid = 1'b1; layer_en = en; layer_idx = idx;
        @(negedge Clk);
        @(negedge Clk);
        chk(name, 32'({Red, Green, Blue}), 32'(exp));
    endtask

    task automatic wr(input logic [2:0] layer, input logic [2:0] idx, input logic [23:0] rgb);
        @(negedge Clk);
        blank_n = 1'b0;
        pal_wr_valid = 1'b1; pal_wr_layer = layer; pal_wr_idx = idx; pal_wr_rgb = rgb;
        #1 chk("wr_ready_in_blank", 32'(pal_wr_ready), 32'd1);
        @(posedge Clk);
        #1 pal_wr_valid = 1'b0;
    endtask

`ifdef PALETTE_FADE_EN
    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge Clk) frame_tick = 1'b1;
            @(negedge Clk) frame_tick = 1'b0;
        end
        @(negedge Clk);
        @(negedge Clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 3'b000, {3'd0, 3'd0, 3'd0}, 10'd0, 10'd0, 24'h000000};
        vecs[1]  = '{1'b1, 1'b1, 3'b110, {3'd0, 3'd4, 3'd2}, 10'd0, 10'd0, 24'hFFFF00};
        vecs[2]  = '{1'b1, 1'b1, 3'b110, {3'd1, 3'd4, 3'd2}, 10'd0, 10'd0, 24'hFF0000};
        vecs[3]  = '{1'b0, 1'b1, 3'b110, {3'd1, 3'd4, 3'd2}, 10'd0, 10'd0, 24'h000000};
        vecs[4]  = '{1'b1, 1'b1, 3'b000, {3'd0, 3'd0, 3'd1}, 10'd0, 10'd0, 24'hFFFFFF};
        vecs[5]  = '{1'b1, 1'b1, 3'b000, {3'd0, 3'd0, 3'd3}, 10'd0, 10'd0, 24'hB6B6AA};
        vecs[6]  = '{1'b1, 1'b1, 3'b010, {3'd0, 3'd0, 3'd2}, 10'd0, 10'd0, 24'h0000FF};
        vecs[7]  = '{1'b1, 1'b1, 3'b010, {3'd5, 3'd6, 3'd0}, 10'd0, 10'd0, 24'hFFB600};
        vecs[8]  = '{1'b1, 1'b1, 3'b110, {3'd7, 3'd3, 3'd0}, 10'd0, 10'd0, 24'h6DB600};
        vecs[9]  = '{1'b1, 1'b0, 3'b000, {3'd0, 3'd0, 3'd1}, 10'd0, 10'd0, 24'hFFFFFF};
        vecs[10] = '{1'b1, 1'b1, 3'b100, {3'd2, 3'd0, 3'd3}, 10'd0, 10'd0, 24'hFFFFFF};
        vecs[11] = '{1'b1, 1'b1, 3'b011, {3'd0, 3'd3, 3'd0}, 10'd0, 10'd0, 24'h6D6D6D};
        vecs[12] = '{1'b1, 1'b1, 3'b101, {3'd0, 3'd0, 3'd2}, 10'd0, 10'd0, 24'h0000FF};
        for (int i = 0; i < NV; i++) begin
            vecs[i].x = 10'(i * 37 + 5);
            vecs[i].y = 10'(i * 11 + 200);
        end

        Reset = 1'b1;
        DrawX = '0; DrawY = '0; pix_valid = 1'b0; blank_n = 1'b0;
        layer_en = '0; layer_idx = '0;
        pal_wr_valid = 1'b0; pal_wr_layer = '0; pal_wr_idx = '0; pal_wr_rgb = '0;
`ifdef PALETTE_FADE_EN
        frame_tick = 1'b0; fade_go = 1'b0; fade_out = 1'b0;
`endif
        repeat (3) @(negedge Clk);
        chk("reset_rgb", 32'({Red, Green, Blue}), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_outxy", 32'({OutX, OutY}), 32'h0);
        Reset = 1'b0;

        // Back-to-back stream: each output must match the vector two cycles earlier.
        for (int i = 0; i < NV + 2; i++) begin
            @(negedge Clk);
            if (i >= 2) begin
                chk($sformatf("vec%0d_rgb", i-2), 32'({Red, Green, Blue}), 32'(vecs[i-2].rgb));
                chk($sformatf("vec%0d_valid", i-2), 32'(out_valid), 32'(vecs[i-2].pv));
                chk($sformatf("vec%0d_outx", i-2), 32'(OutX), 32'(vecs[i-2].x));
                chk($sformatf("vec%0d_outy", i-2), 32'(OutY), 32'(vecs[i-2].y));
            end
            if (i < NV) begin
                blank_n = vecs[i].bl; pix_valid = vecs[i].pv;
                layer_en = vecs[i].en; layer_idx = vecs[i].idx;
                DrawX = vecs[i].x; DrawY = vecs[i].y;
            end
        end

        // Write during visible region is held off and leaves the palette alone.
        @(negedge Clk);
        blank_n = 1'b1; pix_valid = 1'b1; layer_en = 3'b000; layer_idx = {3'd0, 3'd0, 3'd3};
        pal_wr_valid = 1'b1; pal_wr_layer = 3'd0; pal_wr_idx = 3'd3; pal_wr_rgb = 24'h123456;
        #1 chk("wr_ready_visible", 32'(pal_wr_ready), 32'd0);
        repeat (3) @(negedge Clk);
        chk("wr_blocked_old_value", 32'({Red, Green, Blue}), 32'hB6B6AA);
        // Blanking opens the port; the held request completes.
        blank_n = 1'b0;
        #1 chk("wr_ready_blank", 32'(pal_wr_ready), 32'd1);
        @(posedge Clk);
        #1 pal_wr_valid = 1'b0;
        look("bg3_after_write", 3'b000, {3'd0, 3'd0, 3'd3}, 24'h123456);

        // Out-of-range layer: handshake completes, nothing changes.
        wr(3'd5, 3'd4, 24'h010203);
        look("l1_idx4_untouched", 3'b010, {3'd0, 3'd4, 3'd0}, 24'hFFFF00);
        look("l0_idx4_untouched", 3'b000, {3'd0, 3'd0, 3'd4}, 24'h000000);
        look("l2_idx4_untouched", 3'b100, {3'd4, 3'd0, 3'd0}, 24'hFFFF00);

        // Sprite layer write lands only in that layer.
        wr(3'd2, 3'd5, 24'hABCDEF);
        look("l2_idx5_written", 3'b100, {3'd5, 3'd0, 3'd0}, 24'hABCDEF);
        look("l1_idx5_default", 3'b010, {3'd0, 3'd5, 3'd0}, 24'h00FF00);

        // Mid-frame reset: outputs clear at once; palettes return to defaults.
        @(negedge Clk);
        blank_n = 1'b1; pix_valid = 1'b1; layer_en = 3'b000; layer_idx = {3'd0, 3'd0, 3'd1};
        @(negedge Clk);
        @(negedge Clk);
        chk("pre_reset_rgb", 32'({Red, Green, Blue}), 32'hFFFFFF);
        #2 Reset = 1'b1;
        #1 chk("async_reset_rgb", 32'({Red, Green, Blue}), 32'h0);
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        @(negedge Clk) Reset = 1'b0;
        look("bg3_default_after_reset", 3'b000, {3'd0, 3'd0, 3'd3}, 24'hB6B6AA);
        look("l2_idx5_default_after_reset", 3'b100, {3'd5, 3'd0, 3'd0}, 24'h00FF00);

`ifdef PALETTE_FADE_EN
        @(negedge Clk);
        blank_n = 1'b1; pix_valid = 1'b1; layer_en = 3'b000; layer_idx = {3'd0, 3'd0, 3'd1};
        chk("fade_idle_busy", 32'(fade_busy), 32'd0);
        fade_out = 1'b1; fade_go = 1'b1;
        @(negedge Clk) fade_go = 1'b0;
        chk("fade_busy_set", 32'(fade_busy), 32'd1);
        ticks(4);
        chk("fade_out_4", 32'({Red, Green, Blue}), 32'hBFBFBF);
        // go while fading is ignored: direction stays "out".
        fade_out = 1'b0; fade_go = 1'b1;
        @(negedge Clk) fade_go = 1'b0;
        ticks(12);
        chk("fade_out_16", 32'({Red, Green, Blue}), 32'h000000);
        chk("fade_out_done", 32'(fade_busy), 32'd0);
        fade_out = 1'b0; fade_go = 1'b1;
        @(negedge Clk) fade_go = 1'b0;
        ticks(8);
        chk("fade_in_8", 32'({Red, Green, Blue}), 32'h7F7F7F);
        ticks(8);
        chk("fade_in_16", 32'({Red, Green, Blue}), 32'hFFFFFF);
        chk("fade_in_done", 32'(fade_busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
